shape_pixel_renderer: RTL and testbench
=======================================

Name: shape_pixel_renderer

Overview:
- Consumes a 25x25 one-bit glyph bitmap, such as the player-2 banner shape, and scans it out as pixels for the VGA display path.
- At each frame start, the bitmap is copied row by row into a shadow buffer, so a source change mid-frame cannot cause tearing.
- For each incoming pixel coordinate, the block decides whether the pixel falls on glyph ink inside a scaled, positioned window, and outputs a colour.
- Sits between the shape ROMs and the pixel mux / VGA colour output.

Parameters:
SHAPE_W, 25, bitmap columns
SHAPE_H, 25, bitmap rows
SCALE_LOG2, 2, each bitmap cell covers (1<<SCALE_LOG2) x (1<<SCALE_LOG2) screen pixels
COORD_W, 10, width of pixel/origin coordinates
INK_LEVEL, 0, bitmap bit value that means "draw"
FG_COLOR, 12'hFFF, RGB444 colour of ink pixels
BG_COLOR, 12'h000, RGB444 colour of non-ink pixels

Ports:
clk  input  1  system clock
reset_n  input  1  synchronous active-low reset
ishapes  input  [SHAPE_W-1:0] x [0:SHAPE_H-1]  glyph bitmap; row 0 = top; bit SHAPE_W-1 = leftmost column
iframe_start  input  1  one-cycle pulse in vertical blanking; starts shadow load and latches origin
iorigin_x  input  COORD_W  glyph window left edge, latched on iframe_start
iorigin_y  input  COORD_W  glyph window top edge, latched on iframe_start
ienable  input  1  0 forces opixel_on low
ipixel_valid  input  1  ipixel_x/ipixel_y valid this cycle
ipixel_x  input  COORD_W  current pixel column
ipixel_y  input  COORD_W  current pixel row
opixel_valid  output  1  ipixel_valid delayed 2 cycles
opixel_on  output  1  pixel is glyph ink
opixel_color  output  12  FG_COLOR if opixel_on, else BG_COLOR
oloaded  output  1  shadow holds a complete bitmap

Behaviour:
- The clock is clk. Reset is synchronous and active-low: reset_n is sampled on the rising edge of clk.
- Reset values:
  - opixel_valid = 0, opixel_on = 0, opixel_color = BG_COLOR, oloaded = 0.
  - FSM = EMPTY; row counter = 0; latched origin = 0.
  - Every shadow bit is set to ~INK_LEVEL.
  - Pipeline registers are cleared.
- FSM states: EMPTY, LOAD, READY.
  - EMPTY --iframe_start--> LOAD.
  - LOAD: each cycle, copy ishapes[row] to shadow[row] and increment row. After row SHAPE_H-1 is copied, go to READY and set oloaded = 1. The load takes exactly SHAPE_H cycles.
  - READY --iframe_start--> LOAD: row = 0, oloaded = 0.
  - iframe_start while in LOAD is ignored; the load runs to completion and the origin is not re-latched.
- The origin is latched in the same cycle iframe_start is accepted.
- Reset asserted mid-load aborts the load and returns to the full reset state.
- Render pipeline has a fixed latency of 2 cycles, independent of FSM state.
- Stage 1:
  - dx = ipixel_x - ox and dy = ipixel_y - oy, computed at COORD_W+1 bits.
  - inside = (ipixel_x >= ox) && ({1'b0,ipixel_x} < {1'b0,ox} + (SHAPE_W<<SCALE_LOG2)), and likewise for y.
  - col = dx >> SCALE_LOG2; row = dy >> SCALE_LOG2.
  - Register inside, col, row and valid.
- Stage 2:
  - bit = shadow[row][SHAPE_W-1-col].
  - opixel_on = valid && inside && oloaded && ienable_d && (bit == INK_LEVEL).
  - opixel_color follows opixel_on; opixel_valid = valid.
  - ienable_d is ienable delayed one cycle, so it aligns with stage 2.
- The window is clipped at the coordinate limit, never wrapped. Example: with ox = 1000, COORD_W = 10 and extent 100, pixels x = 0..75 are outside.
- When ipixel_valid = 0, opixel_on is 0 two cycles later.
- Pixels arriving during LOAD or EMPTY give opixel_on = 0.
- opixel_valid tracks ipixel_valid exactly in all states, including LOAD and EMPTY.
- Changes to ishapes while in READY have no effect until the next completed load.

Test Plan:
- Reset, no load; drive valid pixels at (120,60) -> opixel_valid follows 2 cycles later; opixel_on = 0; opixel_color = 12'h000; oloaded = 0.
- Diagonal test bitmap (all ones, except column r of row r is 0); origin (100,50); pulse iframe_start; wait 25 cycles -> oloaded = 1.
  - Pixel (100+4c+k, 50+4r+j) for all c, r in 0..24 and k, j in 0..3 -> on iff c == r.
  - Pixel (108,58) -> on; pixel (108,54) -> off.
- Edges with origin (100,50):
  - x = 199 / y = 50 -> inside, cell (0,24).
  - x = 200 -> off.
  - x = 99 -> off.
  - Origin (1000,1000), pixel (5,5) -> off (no wrap).
- Second iframe_start 10 cycles into a load with a new origin -> load completes at cycle 25 and the old origin is kept. Altered ishapes after READY -> output unchanged until the next load.
- Reset_n low at load cycle 12 -> oloaded = 0 and shadow cleared; pixel at (100,50) off after a fresh 25-cycle load with a blank bitmap.
- Valid pattern 1,0,1,1,0 with ienable toggled -> opixel_valid reproduces the pattern exactly 2 cycles later; opixel_on = 0 wherever ienable was 0 one cycle before the sample.

Source files
------------

// File: rtl/shape_pixel_renderer.sv
// Glyph renderer: shadows a 1-bit bitmap at frame start and
// scans it out as scaled, positioned RGB444 pixels.
module shape_pixel_renderer #(
  parameter int          SHAPE_W    = 25,
  parameter int          SHAPE_H    = 25,
  parameter int          SCALE_LOG2 = 2,
  parameter int          COORD_W    = 10,
  parameter logic        INK_LEVEL  = 1'b0,
  parameter logic [11:0] FG_COLOR   = 12'hFFF,
  parameter logic [11:0] BG_COLOR   = 12'h000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [SHAPE_W-1:0] ishapes [0:SHAPE_H-1],
  input  logic               iframe_start,
  input  logic [COORD_W-1:0] iorigin_x,
  input  logic [COORD_W-1:0] iorigin_y,
  input  logic               ienable,
  input  logic               ipixel_valid,
  input  logic [COORD_W-1:0] ipixel_x,
  input  logic [COORD_W-1:0] ipixel_y,
  output logic               opixel_valid,
  output logic               opixel_on,
  output logic [11:0]        opixel_color,
  output logic               oloaded
);

  localparam int RW = $clog2(SHAPE_H);
  localparam int CW = $clog2(SHAPE_W);
  localparam logic [COORD_W:0] EXT_X = (COORD_W+1)'(SHAPE_W << SCALE_LOG2);
  localparam logic [COORD_W:0] EXT_Y = (COORD_W+1)'(SHAPE_H << SCALE_LOG2);

  typedef enum logic [1:0] {EMPTY, LOAD, READY} state_t;

  state_t             state_q, state_d;
  logic [RW-1:0]      row_q, row_d;
  logic               loaded_q, loaded_d;
  logic               latch_org;
  logic               wr_en;
  logic [COORD_W-1:0] ox_q, oy_q;
  logic [SHAPE_W-1:0] shadow_q [0:SHAPE_H-1];

  logic               s1_valid_q, s1_inside_q, en_d_q;
  logic [CW-1:0]      s1_col_q, col_d;
  logic [RW-1:0]      s1_row_q, srow_d;
  logic               inside_d;
  logic [COORD_W:0]   px, py, ox, oy, dx, dy;
  logic [CW-1:0]      bit_idx;
  logic               ink;
  logic               valid_q, on_q;

  // Load sequencer next-state and control
  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    loaded_d  = loaded_q;
    latch_org = 1'b0;
    wr_en     = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (iframe_start) begin
          state_d   = LOAD;
          row_d     = '0;
          latch_org = 1'b1;
        end
      end
      LOAD: begin
        wr_en = 1'b1;
        row_d = row_q + RW'(1);
        if (row_q == RW'(SHAPE_H-1)) begin
          state_d  = READY;
          row_d    = '0;
          loaded_d = 1'b1;
        end
      end
      READY: begin
        if (iframe_start) begin
          state_d   = LOAD;
          row_d     = '0;
          loaded_d  = 1'b0;
          latch_org = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // Sequencer state, origin latch and shadow bitmap
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= EMPTY;
      row_q    <= '0;
      loaded_q <= 1'b0;
      ox_q     <= '0;
      oy_q     <= '0;
      for (int i = 0; i < SHAPE_H; i++)
        shadow_q[i] <= {SHAPE_W{~INK_LEVEL}};
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      loaded_q <= loaded_d;
      if (latch_org) begin
        ox_q <= iorigin_x;
        oy_q <= iorigin_y;
      end
      if (wr_en)
        shadow_q[row_q] <= ishapes[row_q];
    end
  end

  // Stage 1 window test: clipped, never wrapped
  always_comb begin
    px       = {1'b0, ipixel_x};
    py       = {1'b0, ipixel_y};
    ox       = {1'b0, ox_q};
    oy       = {1'b0, oy_q};
    dx       = px - ox;
    dy       = py - oy;
    inside_d = (px >= ox) && (px < ox + EXT_X) &&
               (py >= oy) && (py < oy + EXT_Y);
    col_d    = inside_d ? CW'(dx >> SCALE_LOG2) : '0;
    srow_d   = inside_d ? RW'(dy >> SCALE_LOG2) : '0;
  end

  // Stage 1 registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      s1_valid_q  <= 1'b0;
      s1_inside_q <= 1'b0;
      s1_col_q    <= '0;
      s1_row_q    <= '0;
      en_d_q      <= 1'b0;
    end else begin
      s1_valid_q  <= ipixel_valid;
      s1_inside_q <= inside_d;
      s1_col_q    <= col_d;
      s1_row_q    <= srow_d;
      en_d_q      <= ienable;
    end
  end

  // Stage 2 bitmap lookup; column 0 is the MSB
  always_comb begin
    bit_idx = CW'(SHAPE_W-1) - s1_col_q;
    ink     = (shadow_q[s1_row_q][bit_idx] == INK_LEVEL);
  end

  // Stage 2 output registers
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      on_q    <= 1'b0;
    end else begin
      valid_q <= s1_valid_q;
      on_q    <= s1_valid_q && s1_inside_q && loaded_q && en_d_q && ink;
    end
  end

  assign opixel_valid = valid_q;
  assign opixel_on    = on_q;
  assign opixel_color = on_q ? FG_COLOR : BG_COLOR;
  assign oloaded      = loaded_q;

endmodule

// File: tb/tb_shape_pixel_renderer.sv
// Directed bench for shape_pixel_renderer.
// Each task drives one scenario and checks inline.
module tb_shape_pixel_renderer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [24:0] shapes [0:24];
  logic        frame;
  logic [9:0]  org_x, org_y;
  logic        en;
  logic        pv;
  logic [9:0]  px, py;
  logic        ov, on;
  logic [11:0] col;
  logic        loaded;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shape_pixel_renderer dut (
    .clk(clk), .reset_n(reset_n), .ishapes(shapes),
    .iframe_start(frame), .iorigin_x(org_x), .iorigin_y(org_y),
    .ienable(en), .ipixel_valid(pv), .ipixel_x(px), .ipixel_y(py),
    .opixel_valid(ov), .opixel_on(on), .opixel_color(col),
    .oloaded(loaded)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_diag();
    for (int r = 0; r < 25; r++) begin
      shapes[r] = '1;
      shapes[r][24-r] = 1'b0;
    end
  endtask

  task automatic set_blank();
    for (int r = 0; r < 25; r++) shapes[r] = '1;
  endtask

  task automatic do_load(input int x, input int y);
    org_x = 10'(x);
    org_y = 10'(y);
    frame = 1'b1;
    step();
    frame = 1'b0;
    repeat (25) step();
  endtask

  task automatic probe(input int x, input int y);
    px = 10'(x);
    py = 10'(y);
    pv = 1'b1;
    step();
    pv = 1'b0;
    step();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    px = 10'd120; py = 10'd60; pv = 1'b1;
    repeat (3) step();
    checks++;
    if (ov !== 1'b0 || on !== 1'b0 || col !== 12'h000 || loaded !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: v=%b on=%b col=%h ld=%b want 0 0 000 0",
               ov, on, col, loaded);
    end
    reset_n = 1'b1;
    step();
    checks++;
    if (ov !== 1'b0) begin
      failures++;
      $display("FAIL latency_1: valid=%b want 0", ov);
    end
    pv = 1'b0;
    step();
    checks++;
    if (ov !== 1'b1 || on !== 1'b0 || col !== 12'h000 || loaded !== 1'b0) begin
      failures++;
      $display("FAIL unloaded_pixel: v=%b on=%b col=%h ld=%b want 1 0 000 0",
               ov, on, col, loaded);
    end
    step();
    checks++;
    if (ov !== 1'b0) begin
      failures++;
      $display("FAIL valid_drop: valid=%b want 0", ov);
    end
  endtask

  task automatic test_load_grid();
    bit q[$];
    bit e;
    set_diag();
    org_x = 10'd100; org_y = 10'd50; frame = 1'b1;
    step();
    frame = 1'b0;
    repeat (24) step();
    checks++;
    if (loaded !== 1'b0) begin
      failures++;
      $display("FAIL load_cycle24: loaded=%b want 0", loaded);
    end
    step();
    checks++;
    if (loaded !== 1'b1) begin
      failures++;
      $display("FAIL load_cycle25: loaded=%b want 1", loaded);
    end
    for (int y = 50; y < 150; y++) begin
      for (int x = 100; x < 200; x++) begin
        px = 10'(x); py = 10'(y); pv = 1'b1;
        q.push_back(((x - 100) / 4) == ((y - 50) / 4));
        step();
        if (q.size() == 2) begin
          e = q.pop_front();
          checks++;
          if (ov !== 1'b1 || on !== e || col !== (e ? 12'hFFF : 12'h000)) begin
            failures++;
            $display("FAIL grid x=%0d y=%0d: v=%b on=%b col=%h want on=%b",
                     x - 1, y, ov, on, col, e);
          end
        end
      end
    end
    pv = 1'b0;
    step();
    e = q.pop_front();
    checks++;
    if (on !== e) begin
      failures++;
      $display("FAIL grid_last: on=%b want %b", on, e);
    end
    step();
    probe(108, 58);
    checks++;
    if (on !== 1'b1 || col !== 12'hFFF) begin
      failures++;
      $display("FAIL pix_108_58: on=%b col=%h want 1 fff", on, col);
    end
    probe(108, 54);
    checks++;
    if (on !== 1'b0 || col !== 12'h000) begin
      failures++;
      $display("FAIL pix_108_54: on=%b col=%h want 0 000", on, col);
    end
  endtask

  task automatic test_edges();
    int xs [7] = '{199, 200, 99, 100, 199, 100, 196};
    int ys [7] = '{146, 146, 50, 50, 50, 149, 150};
    bit es [7] = '{1, 0, 0, 1, 0, 0, 0};
    for (int i = 0; i < 7; i++) begin
      probe(xs[i], ys[i]);
      checks++;
      if (on !== es[i]) begin
        failures++;
        $display("FAIL edge x=%0d y=%0d: on=%b want %b", xs[i], ys[i], on, es[i]);
      end
    end
    do_load(1000, 1000);
    probe(5, 5);
    checks++;
    if (on !== 1'b0) begin
      failures++;
      $display("FAIL nowrap_5_5: on=%b want 0", on);
    end
    probe(1000, 1000);
    checks++;
    if (on !== 1'b1) begin
      failures++;
      $display("FAIL org1000_cell0: on=%b want 1", on);
    end
    probe(1023, 1023);
    checks++;
    if (on !== 1'b1) begin
      failures++;
      $display("FAIL org1000_cell5: on=%b want 1", on);
    end
  endtask

  task automatic test_retrigger();
    set_diag();
    org_x = 10'd100; org_y = 10'd50; frame = 1'b1;
    step();
    frame = 1'b0;
    checks++;
    if (loaded !== 1'b0) begin
      failures++;
      $display("FAIL reload_clears: loaded=%b want 0", loaded);
    end
    repeat (9) step();
    org_x = 10'd300; org_y = 10'd300; frame = 1'b1;
    step();
    frame = 1'b0;
    repeat (14) step();
    checks++;
    if (loaded !== 1'b0) begin
      failures++;
      $display("FAIL retrig_cycle24: loaded=%b want 0", loaded);
    end
    step();
    checks++;
    if (loaded !== 1'b1) begin
      failures++;
      $display("FAIL retrig_cycle25: loaded=%b want 1", loaded);
    end
    probe(100, 50);
    checks++;
    if (on !== 1'b1) begin
      failures++;
      $display("FAIL old_origin: on=%b want 1", on);
    end
    probe(300, 300);
    checks++;
    if (on !== 1'b0) begin
      failures++;
      $display("FAIL new_origin_ignored: on=%b want 0", on);
    end
    set_blank();
    repeat (3) step();
    probe(100, 50);
    checks++;
    if (on !== 1'b1) begin
      failures++;
      $display("FAIL shadow_hold: on=%b want 1", on);
    end
    do_load(100, 50);
    probe(100, 50);
    checks++;
    if (on !== 1'b0) begin
      failures++;
      $display("FAIL shadow_reload: on=%b want 0", on);
    end
  endtask

  task automatic test_reset_midload();
    set_diag();
    org_x = 10'd100; org_y = 10'd50; frame = 1'b1;
    step();
    frame = 1'b0;
    repeat (12) step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    checks++;
    if (loaded !== 1'b0 || on !== 1'b0) begin
      failures++;
      $display("FAIL midload_reset: ld=%b on=%b want 0 0", loaded, on);
    end
    repeat (20) step();
    checks++;
    if (loaded !== 1'b0) begin
      failures++;
      $display("FAIL load_aborted: loaded=%b want 0", loaded);
    end
    set_blank();
    do_load(100, 50);
    checks++;
    if (loaded !== 1'b1) begin
      failures++;
      $display("FAIL fresh_load: loaded=%b want 1", loaded);
    end
    probe(100, 50);
    checks++;
    if (on !== 1'b0) begin
      failures++;
      $display("FAIL blank_100_50: on=%b want 0", on);
    end
    probe(108, 58);
    checks++;
    if (on !== 1'b0) begin
      failures++;
      $display("FAIL blank_108_58: on=%b want 0", on);
    end
  endtask

  task automatic test_back_to_back();
    bit vp [5] = '{1, 0, 1, 1, 0};
    bit ep [5] = '{1, 1, 0, 1, 0};
    set_diag();
    do_load(100, 50);
    px = 10'd108; py = 10'd58;
    for (int i = 0; i < 6; i++) begin
      pv = (i < 5) ? vp[i] : 1'b0;
      en = (i < 5) ? ep[i] : 1'b1;
      step();
      if (i >= 1) begin
        checks++;
        if (ov !== vp[i-1] || on !== (vp[i-1] & ep[i-1])) begin
          failures++;
          $display("FAIL pattern[%0d]: v=%b on=%b want %b %b",
                   i - 1, ov, on, vp[i-1], vp[i-1] & ep[i-1]);
        end
      end
    end
    pv = 1'b0;
    en = 1'b1;
    step();
  endtask

  initial begin
    reset_n = 1'b0;
    frame = 1'b0;
    org_x = '0; org_y = '0;
    en = 1'b1;
    pv = 1'b0;
    px = '0; py = '0;
    set_blank();
    test_reset();
    test_load_grid();
    test_edges();
    test_retrigger();
    test_reset_midload();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
